// File: rtl/uart_pkg.sv
// Shared UART constants: default divisors (50 MHz system clock) and the
// oversample-phase width helper used by the baud generators.
package uart_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int OVS_DEFAULT = 16;

  // Period = int + 1 + frac/16 clk cycles per oversample tick.
  localparam logic [15:0] DIV_115200_INT  = 16'd26;
  localparam logic [3:0]  DIV_115200_FRAC = 4'd2;
  localparam logic [15:0] DIV_9600_INT    = 16'd324;
  localparam logic [3:0]  DIV_9600_FRAC   = 4'd8;

  function automatic int phase_w(input int ovs);
    return (ovs <= 2) ? 1 : $clog2(ovs);
  endfunction

endpackage

// File: rtl/frac_accum.sv
// First-order fractional accumulator: each step adds inc modulo 2^FRAC_W and
// registers the overflow as carry.
module frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] inc,
  output logic [FRAC_W-1:0] acc,
  output logic              carry
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      {carry, acc} <= {1'b0, acc} + {1'b0, inc};
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick from an int.frac divisor, plus
// mid-bit / bit-boundary strobes, phase and legacy br square wave.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int                DIV_W    = 16,
  parameter int                FRAC_W   = 4,
  parameter int                OVS      = OVS_DEFAULT,
  parameter logic [DIV_W-1:0]  DEF_INT  = 16'd26,
  parameter logic [FRAC_W-1:0] DEF_FRAC = 4'd0,
  localparam int               PH_W     = phase_w(OVS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              br,
  output logic [PH_W-1:0]   os_phase
);

  logic [DIV_W-1:0]  sh_int, act_int, nxt_int;
  logic [FRAC_W-1:0] sh_frac, act_frac, nxt_frac;
  logic [DIV_W:0]    cnt, lim;
  logic [FRAC_W-1:0] acc;
  logic              carry, wrap;

  // A load on the same edge as a tick must reach the next period directly.
  assign nxt_int  = div_load ? div_int  : sh_int;
  assign nxt_frac = div_load ? div_frac : sh_frac;
  assign lim      = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
  assign wrap     = en && (cnt == lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_int  <= DEF_INT;
      sh_frac <= DEF_FRAC;
    end else if (div_load) begin
      sh_int  <= div_int;
      sh_frac <= div_frac;
    end
  end

  // Active divisor only changes at a period boundary or while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
    end else if (!en || wrap) begin
      act_int  <= nxt_int;
      act_frac <= nxt_frac;
    end
  end

  frac_accum #(.FRAC_W(FRAC_W)) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr   (!en),
    .step  (wrap),
    .inc   (act_frac),
    .acc   (acc),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      br       <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (wrap) begin
      cnt      <= '0;
      os_phase <= os_phase + PH_W'(1);
      os_tick  <= 1'b1;
      mid_tick <= (os_phase == PH_W'(OVS/2 - 1));
      bit_tick <= (os_phase == PH_W'(OVS - 1));
      if (os_phase == PH_W'(OVS - 1)) br <= ~br;
    end else begin
      cnt      <= cnt + (DIV_W+1)'(1);
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

  logic unused;
  assign unused = ^acc;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: period tables plus hand-built sequences
// for loads, enable gating and asynchronous reset.
module tb_baud_gen_frac;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        os_tick, mid_tick, bit_tick, br;
  logic [3:0]  os_phase;

  baud_gen_frac dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .div_load(div_load), .os_tick(os_tick), .mid_tick(mid_tick),
    .bit_tick(bit_tick), .br(br), .os_phase(os_phase)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    int dint;
    int dfrac;
    int p[6];
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts falling edges until the chosen strobe is seen (0=os,1=mid,2=bit).
  task automatic wait_sig(input int which, input int lim, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = (which == 0) ? os_tick : (which == 1) ? mid_tick : bit_tick;
    end while (!s && n < lim);
    if (!s) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout waiting for strobe %0d after %0d cycles", which, n);
    end
  endtask

  task automatic load_idle(input int di, input int df);
    @(negedge clk);
    en = 1'b0; div_load = 1'b1; div_int = 16'(di); div_frac = 4'(df);
    @(negedge clk);
    div_load = 1'b0; en = 1'b1;
  endtask

  // Measures one period while pulsing div_load at cycle offsets a1/a2.
  task automatic period_ld(input int a1, input int v1, input int a2, input int v2,
                           output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      s = os_tick;
      div_load = 1'b0;
      if (!s && n == a1) begin div_load = 1'b1; div_int = 16'(v1); end
      if (!s && n == a2) begin div_load = 1'b1; div_int = 16'(v2); end
    end while (!s && n < 200);
    div_load = 1'b0;
    if (!s) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout in loaded period after %0d cycles", n);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int   n, k, sum;
    logic br0;

    vecs[0] = '{3, 8,  '{4, 4, 5, 4, 5, 4}};
    vecs[1] = '{0, 0,  '{1, 1, 1, 1, 1, 1}};
    vecs[2] = '{9, 0,  '{10, 10, 10, 10, 10, 10}};
    vecs[3] = '{2, 4,  '{3, 3, 3, 3, 4, 3}};
    vecs[4] = '{5, 15, '{6, 6, 7, 7, 7, 7}};
    vecs[5] = '{1, 1,  '{2, 2, 2, 2, 2, 2}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst os_tick", os_tick, 0);
    check("rst mid_tick", mid_tick, 0);
    check("rst bit_tick", bit_tick, 0);
    check("rst br", br, 0);
    check("rst os_phase", os_phase, 0);

    // Default divisor 26 -> 27-cycle ticks, 432-cycle bits
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    wait_sig(0, 100, n);  check("def first tick", n, 27);
    wait_sig(0, 100, n);  check("def period", n, 27);
    wait_sig(2, 1000, n); check("def to bit_tick", n, 14 * 27);
    check("def br after bit", br, 1);
    check("def phase after bit", os_phase, 0);
    wait_sig(1, 1000, n); check("def bit to mid", n, 216);
    check("def phase after mid", os_phase, 8);
    wait_sig(2, 1000, n); check("def mid to bit", n, 216);
    check("def br toggled back", br, 0);

    // Period tables
    foreach (vecs[i]) begin
      load_idle(vecs[i].dint, vecs[i].dfrac);
      for (int j = 0; j < 6; j++) begin
        wait_sig(0, 200, n);
        check($sformatf("vec%0d int=%0d frac=%0d period%0d", i, vecs[i].dint,
                        vecs[i].dfrac, j), n, vecs[i].p[j]);
      end
    end

    // Average of 4.5 cycles over 32 ticks
    load_idle(3, 8);
    wait_sig(0, 200, n);
    sum = 0;
    for (int j = 0; j < 32; j++) begin
      wait_sig(0, 200, n);
      sum += n;
    end
    check("frac 3.5 sum of 32 periods", sum, 144);

    // int=0: tick every cycle, bit every 16
    load_idle(0, 0);
    br0 = br;
    wait_sig(2, 100, n); check("int0 first bit", n, 16);
    check("int0 br toggled", br, !br0);
    wait_sig(2, 100, n); check("int0 bit period", n, 16);
    check("int0 br toggled again", br, br0);

    // Glitch-free load, last-wins, load on the tick edge
    load_idle(9, 0);
    wait_sig(0, 100, n);           check("ld first period", n, 10);
    period_ld(5, 4, 0, 0, n);      check("ld period not truncated", n, 10);
    wait_sig(0, 100, n);           check("ld new period a", n, 5);
    wait_sig(0, 100, n);           check("ld new period b", n, 5);
    period_ld(1, 7, 2, 2, n);      check("ld double within period", n, 5);
    wait_sig(0, 100, n);           check("ld last value wins", n, 3);
    period_ld(2, 6, 0, 0, n);      check("ld on tick edge current", n, 3);
    wait_sig(0, 100, n);           check("ld on tick edge next", n, 7);

    // Largest divisor
    load_idle(16'hFFFF, 0);
    wait_sig(0, 70000, n);         check("int FFFF period", n, 65536);

    // Enable gating from a known reset state
    @(negedge clk); rst = 1'b0; en = 1'b0;
    @(negedge clk); rst = 1'b1;
    load_idle(1, 0);
    wait_sig(2, 200, n);           check("en to bit_tick", n, 32);
    check("en br set", br, 1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    check("en off os_tick", os_tick, 0);
    check("en off os_phase", os_phase, 0);
    check("en off br held", br, 1);
    k = 0;
    repeat (5) begin @(negedge clk); k += int'(os_tick); end
    check("en off no ticks", k, 0);
    en = 1'b1;
    wait_sig(0, 100, n);           check("en reassert first tick", n, 2);
    check("en reassert phase", os_phase, 1);
    k = 1;
    while (!mid_tick && k < 40) begin wait_sig(0, 100, n); k++; end
    check("en mid at tick", k, 8);

    // Asynchronous reset between edges
    load_idle(0, 0);
    repeat (3) @(negedge clk);
    check("pre-rst os_tick", os_tick, 1);
    check("pre-rst br", br, 1);
    #2 rst = 1'b0;
    #1;
    check("async os_tick", os_tick, 0);
    check("async os_phase", os_phase, 0);
    check("async br", br, 0);
    @(negedge clk); rst = 1'b1;
    wait_sig(0, 100, n);           check("post-rst default period", n, 27);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
